fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Consumer side of the program-counter interface.
- Reads the current address from the PC register (PC output), fetches the instruction from instruction memory over a req/ack handshake, and hands it to decode with valid/ready.
- Computes the next address (increment or branch target) and drives it back into the PC register's address input.
- Sits between the PC register, instruction memory and decode.

Parameters:
- AW, 8, width of PC/memory address.
- DW, 16, instruction word width.
- TIMEOUT, 15, max cycles to wait for mem_ack before aborting the fetch (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- fetch_en  input  1  permits starting a new fetch
- pc_in  input  AW  current PC value (PC register output)
- pc_next  output  AW  next address, driven to PC register input
- mem_req  output  1  memory read request
- mem_addr  output  AW  memory read address
- mem_ack  input  1  memory read complete; mem_data valid this cycle
- mem_data  input  DW  memory read data
- instr  output  DW  fetched instruction
- instr_valid  output  1  instr valid to decode
- instr_ready  input  1  decode accepts instr
- branch_take  input  1  redirect request, single-cycle
- branch_target  input  AW  redirect address
- fetch_err  output  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - pc_next=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0, fetch_err=0.
  - Timeout counter=0, flush=0, state=IDLE.
  - Reset mid-fetch abandons the request; a late mem_ack after reset is ignored.
- All outputs are registered. States: IDLE, WAIT, HOLD, SYNC.
- IDLE:
  - fetch_en=1 and branch_take=0 -> WAIT. Set mem_req=1, mem_addr=pc_in, counter=0.
  - Otherwise stay.
- WAIT:
  - mem_req is held high and mem_addr is held stable until ack or timeout.
  - mem_ack=1, flush=0 -> HOLD. Set instr=mem_data, instr_valid=1, mem_req=0, pc_next=mem_addr+1 (mod 2^AW; 8'hFF wraps to 8'h00).
  - mem_ack=1, flush=1 -> SYNC. Data discarded, instr_valid stays 0, mem_req=0, flush=0.
  - No ack and counter==TIMEOUT-1 -> SYNC. Set mem_req=0, fetch_err=1 for exactly one cycle. pc_next is unchanged, so the same address is retried.
  - Otherwise the counter increments.
- HOLD:
  - instr and instr_valid are held until instr_ready=1.
  - On instr_ready=1 -> SYNC with instr_valid=0.
- SYNC: unconditional one-cycle state -> IDLE. This guarantees the PC register has latched pc_next before pc_in is sampled again.
- Minimum fetch latency is 1 cycle of mem_req (ack on the first WAIT cycle). Back-to-back throughput is at most one instruction per 4 cycles with zero-wait memory and ready tied high.
- branch_take:
  - Has priority over increment in the same cycle, in every state.
  - IDLE/SYNC/HOLD: pc_next=branch_target, instr_valid=0 (HOLD instruction dropped), -> SYNC.
  - WAIT: pc_next=branch_target, flush=1; mem_req is held until ack or timeout (the request is never withdrawn mid-handshake).
  - branch_take coincident with mem_ack in WAIT: response discarded, pc_next=branch_target, -> SYNC.
  - branch_take coincident with timeout in WAIT: fetch_err pulses, pc_next=branch_target, flush cleared.
- instr_ready while instr_valid=0 has no effect.
- fetch_en=0 only blocks leaving IDLE. An in-flight fetch completes normally.
- mem_ack outside WAIT is ignored.

Test Plan:
- Reset held 2 cycles, then released with fetch_en=1, pc_in=8'h00, memory acks 1 cycle after req with 16'hA5A5, instr_ready=1 -> mem_addr=00, instr=A5A5 with instr_valid high 1 cycle, pc_next=01. Next request issued with mem_addr=01 after SYNC.
- pc_in=8'hFF, ack with 16'h1234 -> pc_next=8'h00 (wrap), instr=1234.
- instr_ready held low 5 cycles after ack -> instr_valid and instr stay stable for 5 cycles, no new mem_req. Drops the cycle after ready rises.
- branch_take with target 8'h40 pulsed during WAIT, ack 3 cycles later with 16'hDEAD -> instr_valid never rises, pc_next=40, next mem_addr=40.
- mem_ack never asserted, TIMEOUT=15 -> mem_req high exactly 15 cycles, then fetch_err pulses once, pc_next unchanged, request reissued to the same address.
- Reset asserted during WAIT with mem_req high -> next cycle all outputs 0, state IDLE. A subsequent stray mem_ack produces no instr_valid.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: consumer side of the program-counter interface.
// Samples the PC register output, fetches one instruction word from instruction
// memory over a req/ack handshake, presents it to decode with valid/ready and
// drives the next address (increment or branch target) back to the PC register.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   fetch_en              permits starting a new fetch from IDLE
//   pc_in / pc_next       current PC in, next PC out to the PC register
//   mem_req/mem_addr      memory read request and address (held until ack/timeout)
//   mem_ack/mem_data      memory read completion and data
//   instr/instr_valid     fetched instruction to decode
//   instr_ready           decode accepts instr
//   branch_take/target    single-cycle redirect request and address
//   fetch_err             one-cycle pulse when a fetch times out
module fetch_sequencer #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    input  logic [AW-1:0] pc_in,
    output logic [AW-1:0] pc_next,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          branch_take,
    input  logic [AW-1:0] branch_target,
    output logic          fetch_err
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StHold, StSync} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic [AW-1:0] pc_next_q, pc_next_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            pc_next_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            pc_next_q  <= pc_next_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        pc_next_d  = pc_next_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        err_d      = 1'b0;

        // A redirect always wins over the increment; in WAIT it only retargets
        // pc_next, the outstanding request itself runs to ack or timeout.
        if (branch_take) begin
            pc_next_d = branch_target;
        end

        unique case (state_q)
            StIdle: begin
                if (branch_take) begin
                    valid_d = 1'b0;
                    state_d = StSync;
                end else if (fetch_en) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_in;
                    cnt_d      = '0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    flush_d   = 1'b0;
                    if (branch_take || flush_q) begin
                        // Response belongs to a redirected stream: drop it.
                        state_d = StSync;
                    end else begin
                        instr_d   = mem_data;
                        valid_d   = 1'b1;
                        pc_next_d = mem_addr_q + AW'(1);
                        state_d   = StHold;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // pc_next untouched unless redirected, so the same address is retried.
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    flush_d   = 1'b0;
                    state_d   = StSync;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (branch_take) begin
                        flush_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (branch_take || instr_ready) begin
                    valid_d = 1'b0;
                    state_d = StSync;
                end
            end
            StSync: begin
                // Extra cycle lets the PC register latch pc_next before pc_in is reused.
                state_d = branch_take ? StSync : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pc_next     = pc_next_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A tiny PC register model feeds pc_next
// back to pc_in; pc_force overrides it when a test needs a specific address.
module tb_fetch_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_next;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          branch_take;
    logic [AW-1:0] branch_target;
    logic          fetch_err;

    logic [AW-1:0] pc_reg;
    logic          pc_force_en;
    logic [AW-1:0] pc_force;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) pc_reg <= pc_next;
    assign pc_in = pc_force_en ? pc_force : pc_reg;

    fetch_sequencer #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_take  (branch_take),
        .branch_target(branch_target),
        .fetch_err    (fetch_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Two reset cycles; leaves reset asserted until the caller releases it.
    task automatic apply_reset();
        reset       = 1'b1;
        mem_ack     = 1'b0;
        branch_take = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        fetch_en      = 1'b1;
        mem_ack       = 1'b0;
        mem_data      = '0;
        instr_ready   = 1'b1;
        branch_take   = 1'b0;
        branch_target = '0;
        pc_force_en   = 1'b0;
        pc_force      = '0;

        // Test 1: reset values, basic fetch at 00, next request at 01
        apply_reset();
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_pc_next", 32'(pc_next), 32'h0);
        check_eq("rst_instr", 32'(instr), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_err", 32'(fetch_err), 32'h0);
        reset = 1'b0;
        tick();
        check_eq("t1_req", 32'(mem_req), 32'h1);
        check_eq("t1_addr", 32'(mem_addr), 32'h00);
        mem_ack  = 1'b1;
        mem_data = 16'hA5A5;
        tick();
        mem_ack = 1'b0;
        check_eq("t1_valid", 32'(instr_valid), 32'h1);
        check_eq("t1_instr", 32'(instr), 32'hA5A5);
        check_eq("t1_pc_next", 32'(pc_next), 32'h01);
        check_eq("t1_req_low", 32'(mem_req), 32'h0);
        tick();
        check_eq("t1_valid_drop", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t1_sync_no_req", 32'(mem_req), 32'h0);
        tick();
        check_eq("t1_req2", 32'(mem_req), 32'h1);
        check_eq("t1_addr2", 32'(mem_addr), 32'h01);

        // Test 2: address FF wraps to 00
        fetch_en = 1'b0;
        apply_reset();
        pc_force_en = 1'b1;
        pc_force    = 8'hFF;
        fetch_en    = 1'b1;
        reset       = 1'b0;
        tick();
        check_eq("t2_addr", 32'(mem_addr), 32'hFF);
        mem_ack  = 1'b1;
        mem_data = 16'h1234;
        tick();
        mem_ack = 1'b0;
        check_eq("t2_pc_wrap", 32'(pc_next), 32'h00);
        check_eq("t2_instr", 32'(instr), 32'h1234);
        check_eq("t2_valid", 32'(instr_valid), 32'h1);

        // Test 3: decode stalls, instr held stable, no new request
        apply_reset();
        pc_force    = 8'h10;
        instr_ready = 1'b0;
        reset       = 1'b0;
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_hold_valid", 32'(instr_valid), 32'h1);
            check_eq("t3_hold_instr", 32'(instr), 32'hBEEF);
            check_eq("t3_hold_no_req", 32'(mem_req), 32'h0);
            tick();
        end
        check_eq("t3_hold_last", 32'(instr_valid), 32'h1);
        instr_ready = 1'b1;
        tick();
        check_eq("t3_drop", 32'(instr_valid), 32'h0);

        // Test 4: branch during WAIT flushes the late response
        apply_reset();
        pc_force = 8'h20;
        reset    = 1'b0;
        tick();
        check_eq("t4_addr", 32'(mem_addr), 32'h20);
        branch_take   = 1'b1;
        branch_target = 8'h40;
        tick();
        branch_take = 1'b0;
        check_eq("t4_req_held", 32'(mem_req), 32'h1);
        check_eq("t4_addr_held", 32'(mem_addr), 32'h20);
        check_eq("t4_pc_branch", 32'(pc_next), 32'h40);
        tick();
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'hDEAD;
        tick();
        mem_ack     = 1'b0;
        pc_force_en = 1'b0;
        check_eq("t4_no_valid", 32'(instr_valid), 32'h0);
        check_eq("t4_req_low", 32'(mem_req), 32'h0);
        check_eq("t4_pc_keep", 32'(pc_next), 32'h40);
        tick();
        check_eq("t4_sync_valid", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t4_req_next", 32'(mem_req), 32'h1);
        check_eq("t4_addr_next", 32'(mem_addr), 32'h40);

        // Test 5: no ack -> 15 cycles of mem_req, one error pulse, retry at 40
        for (int i = 0; i < 15; i++) begin
            check_eq("t5_req_high", 32'(mem_req), 32'h1);
            check_eq("t5_no_err", 32'(fetch_err), 32'h0);
            tick();
        end
        check_eq("t5_req_low", 32'(mem_req), 32'h0);
        check_eq("t5_err", 32'(fetch_err), 32'h1);
        check_eq("t5_pc_same", 32'(pc_next), 32'h40);
        tick();
        check_eq("t5_err_once", 32'(fetch_err), 32'h0);
        tick();
        check_eq("t5_retry_req", 32'(mem_req), 32'h1);
        check_eq("t5_retry_addr", 32'(mem_addr), 32'h40);

        // Test 6: reset mid-WAIT, then stray ack ignored
        reset = 1'b1;
        tick();
        check_eq("t6_req", 32'(mem_req), 32'h0);
        check_eq("t6_addr", 32'(mem_addr), 32'h0);
        check_eq("t6_pc", 32'(pc_next), 32'h0);
        check_eq("t6_instr", 32'(instr), 32'h0);
        check_eq("t6_valid", 32'(instr_valid), 32'h0);
        reset    = 1'b0;
        fetch_en = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'hFFFF;
        tick();
        mem_ack = 1'b0;
        check_eq("t6_stray_valid", 32'(instr_valid), 32'h0);
        check_eq("t6_stray_req", 32'(mem_req), 32'h0);
        tick();
        check_eq("t6_idle_valid", 32'(instr_valid), 32'h0);

        // Test 7: branch coincident with ack discards the response
        apply_reset();
        fetch_en    = 1'b1;
        pc_force_en = 1'b1;
        pc_force    = 8'h50;
        reset       = 1'b0;
        tick();
        mem_ack       = 1'b1;
        mem_data      = 16'h1111;
        branch_take   = 1'b1;
        branch_target = 8'h77;
        tick();
        mem_ack     = 1'b0;
        branch_take = 1'b0;
        check_eq("t7_valid", 32'(instr_valid), 32'h0);
        check_eq("t7_pc", 32'(pc_next), 32'h77);
        check_eq("t7_req", 32'(mem_req), 32'h0);

        // Test 8: branch in HOLD drops the held instruction
        apply_reset();
        pc_force    = 8'h60;
        instr_ready = 1'b0;
        reset       = 1'b0;
        tick();
        mem_ack  = 1'b1;
        mem_data = 16'h2222;
        tick();
        mem_ack = 1'b0;
        check_eq("t8_valid", 32'(instr_valid), 32'h1);
        check_eq("t8_pc_inc", 32'(pc_next), 32'h61);
        branch_take   = 1'b1;
        branch_target = 8'h99;
        tick();
        branch_take = 1'b0;
        check_eq("t8_dropped", 32'(instr_valid), 32'h0);
        check_eq("t8_pc", 32'(pc_next), 32'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
